// File: rtl/player_cursor.sv
// player_cursor: push-button front end and 8x8 board cursor for the game Controller.
// Synchronises and debounces five raw keys. Moves the cursor with wrap-around.
// Commits a move (o_player_done) only while the Controller awaits a human move,
// and only to an empty cell. Confirms on an occupied cell pulse o_reject instead.
//
// Optional build macro: CURSOR_AUTOREPEAT_EN. When it is defined, a held direction
// key repeats after REPEAT_DELAY cycles and then every REPEAT_RATE cycles.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_key_up/down/left/right/ok  raw active-high buttons (asynchronous)
//   i_enable               Controller is waiting for a player move
//   i_board[127:0]         2 bits per cell, index 8*row+col, 2'b00 = empty
//   o_row, o_col           cursor position
//   o_player_done          one-cycle commit pulse
//   o_reject               one-cycle pulse: confirm on an occupied cell
//   o_busy                 high while selecting ("your turn" LED)
module player_cursor #(
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_up,
  input  logic         i_key_down,
  input  logic         i_key_left,
  input  logic         i_key_right,
  input  logic         i_key_ok,
  input  logic         i_enable,
  input  logic [127:0] i_board,
  output logic [2:0]   o_row,
  output logic [2:0]   o_col,
  output logic         o_player_done,
  output logic         o_reject,
  output logic         o_busy
);

  localparam int unsigned NK = 5;
  localparam int unsigned DW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {S_WAIT, S_SELECT, S_DONE, S_HOLD} state_e;

  state_e          state;
  logic [NK-1:0]   raw;
  logic [NK-1:0]   sync1;
  logic [NK-1:0]   sync2;
  logic [NK-1:0]   deb;
  logic [NK-1:0]   deb_d;
  logic [DW-1:0]   db_cnt [NK];
  logic [NK-1:0]   press_c;
  logic [3:0]      move_c;
  logic            ok_c;
  logic            cell_empty_c;
  logic            cursor_live_c;

  // Key order: bit 0 up, 1 down, 2 left, 3 right, 4 ok.
  assign raw = {i_key_ok, i_key_right, i_key_left, i_key_down, i_key_up};

  // Two-flop synchroniser, debounce counters and a delayed copy for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NK; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NK; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYC)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Press event: debounced rising edge, one cycle wide.
  assign press_c = deb & ~deb_d;
  assign ok_c    = press_c[4];

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] rep_cnt [4];
  logic [3:0]    rep_fire_c;

  // rep_cnt counts cycles since the press; after the first repeat it is reloaded
  // so that it hits REPEAT_DELAY again exactly REPEAT_RATE cycles later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!deb[i]) begin
          rep_cnt[i] <= '0;
        end else if (rep_fire_c[i]) begin
          rep_cnt[i] <= RW'(REPEAT_DELAY - REPEAT_RATE + 1);
        end else begin
          rep_cnt[i] <= rep_cnt[i] + RW'(1);
        end
      end
    end
  end

  always_comb begin
    rep_fire_c = '0;
    for (int i = 0; i < 4; i++) begin
      rep_fire_c[i] = deb[i] && (rep_cnt[i] == RW'(REPEAT_DELAY));
    end
  end

  assign move_c = press_c[3:0] | rep_fire_c;
`else
  logic unused_repeat;
  assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign move_c = press_c[3:0];
`endif

  assign cell_empty_c = (i_board[{o_row, o_col, 1'b0} +: 2] == 2'b00);

  // Cursor is frozen in DONE/HOLD; a move coinciding with an evaluated ok is dropped.
  assign cursor_live_c = ((state == S_WAIT) || (state == S_SELECT)) &&
                         !((state == S_SELECT) && ok_c);

  // FSM, registered outputs and cursor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_WAIT;
      o_row         <= '0;
      o_col         <= '0;
      o_player_done <= 1'b0;
      o_reject      <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_player_done <= 1'b0;
      o_reject      <= 1'b0;
      case (state)
        S_WAIT: begin
          if (i_enable) begin
            state  <= S_SELECT;
            o_busy <= 1'b1;
          end
        end
        S_SELECT: begin
          if (!i_enable) begin
            state  <= S_WAIT;
            o_busy <= 1'b0;
          end else if (ok_c) begin
            if (cell_empty_c) begin
              state         <= S_DONE;
              o_busy        <= 1'b0;
              o_player_done <= 1'b1;
            end else begin
              o_reject <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_HOLD;
        S_HOLD: begin
          if (!i_enable) state <= S_WAIT;
        end
        default: begin
          state  <= S_WAIT;
          o_busy <= 1'b0;
        end
      endcase

      if (cursor_live_c) begin
        if (move_c[0])      o_row <= o_row - 3'd1;
        else if (move_c[1]) o_row <= o_row + 3'd1;
        else if (move_c[2]) o_col <= o_col - 3'd1;
        else if (move_c[3]) o_col <= o_col + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_player_cursor.sv
// Directed self-checking bench for player_cursor (DEBOUNCE_CYC=4, REPEAT_DELAY=20,
// REPEAT_RATE=5). Inputs change after the falling edge; outputs sampled there too.
module tb_player_cursor;

  logic         clk;
  logic         rst_n;
  logic [4:0]   keys;      // 0 up, 1 down, 2 left, 3 right, 4 ok
  logic         enable;
  logic [127:0] board;
  logic [2:0]   row;
  logic [2:0]   col;
  logic         done;
  logic         reject;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int reject_cnt = 0;
  logic [2:0] done_row = '0;
  logic [2:0] done_col = '0;
  int d0, r0;
  bit found;

  player_cursor #(
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_up     (keys[0]),
    .i_key_down   (keys[1]),
    .i_key_left   (keys[2]),
    .i_key_right  (keys[3]),
    .i_key_ok     (keys[4]),
    .i_enable     (enable),
    .i_board      (board),
    .o_row        (row),
    .o_col        (col),
    .o_player_done(done),
    .o_reject     (reject),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts cycles each pulse is high and captures cursor at commit.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_row = row;
      done_col = col;
    end
    if (reject) reject_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    keys   = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Clean press: held well past debounce, short of the first auto-repeat.
  task automatic press(input int k);
    @(negedge clk);
    keys[k] = 1'b1;
    repeat (8) @(negedge clk);
    keys[k] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic bounce(input int k);
    @(negedge clk);
    keys[k] = 1'b1;
    repeat (2) @(negedge clk);
    keys[k] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    keys   = '0;
    enable = 1'b0;
    board  = '0;
    repeat (3) @(negedge clk);
    chk("rst_row", 32'(row), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Held right key: exact latency, single move.
    keys[3] = 1'b1;
    repeat (7) @(negedge clk);
    chk("right_before_lat", 32'(col), 0);
    @(negedge clk);
    chk("right_at_lat", 32'(col), 1);
    repeat (2) @(negedge clk);
    keys[3] = 1'b0;
    repeat (10) @(negedge clk);
    chk("right_hold_col", 32'(col), 1);
    chk("right_hold_row", 32'(row), 0);

    // Wrap-around from the origin.
    do_reset();
    press(2);
    chk("wrap_left_col", 32'(col), 7);
    press(0);
    chk("wrap_up_row", 32'(row), 7);

    // Bounced keys produce nothing, even while selecting.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("select_busy", 32'(busy), 1);
    d0 = done_cnt;
    r0 = reject_cnt;
    bounce(4);
    bounce(3);
    chk("bounce_ok_done", 32'(done_cnt - d0), 0);
    chk("bounce_ok_reject", 32'(reject_cnt - r0), 0);
    chk("bounce_right_col", 32'(col), 7);

    // Clean ok press while disabled is ignored.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("wait_busy", 32'(busy), 0);
    d0 = done_cnt;
    press(4);
    chk("disabled_ok_done", 32'(done_cnt - d0), 0);

    // Commit at (2,3) on an empty cell.
    do_reset();
    press(1);
    press(1);
    press(3);
    press(3);
    press(3);
    chk("pos_row", 32'(row), 2);
    chk("pos_col", 32'(col), 3);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    press(4);
    chk("commit_pulses", 32'(done_cnt - d0), 1);
    chk("commit_row", 32'(done_row), 2);
    chk("commit_col", 32'(done_col), 3);
    chk("hold_busy", 32'(busy), 0);
    press(3);
    chk("hold_frozen_col", 32'(col), 3);
    d0 = done_cnt;
    press(4);
    chk("hold_second_ok", 32'(done_cnt - d0), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    press(4);
    chk("rearm_commit", 32'(done_cnt - d0), 1);

    // Occupied cell (2,3) is refused; neighbour (2,4) is accepted.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    board[39:38] = 2'b01;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    r0 = reject_cnt;
    press(4);
    chk("occ_reject", 32'(reject_cnt - r0), 1);
    chk("occ_done", 32'(done_cnt - d0), 0);
    chk("occ_busy", 32'(busy), 1);
    press(3);
    chk("occ_move_col", 32'(col), 4);
    d0 = done_cnt;
    press(4);
    chk("next_cell_commit", 32'(done_cnt - d0), 1);
    enable = 1'b0;
    board  = '0;

    // Held down key: auto-repeat when built in, single move otherwise.
    do_reset();
    @(negedge clk);
    keys[1] = 1'b1;
    repeat (40) @(negedge clk);
    keys[1] = 1'b0;
    repeat (10) @(negedge clk);
`ifdef CURSOR_AUTOREPEAT_EN
    chk("hold_down_row", 32'(row), 5);
`else
    chk("hold_down_row", 32'(row), 1);
`endif

    // Reset mid-debounce while selecting clears everything at once.
    press(3);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    keys[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_row", 32'(row), 0);
    chk("midrst_col", 32'(col), 0);
    chk("midrst_busy", 32'(busy), 0);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during the DONE cycle kills the pulse immediately.
    keys[4] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("done_seen_before_rst", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("done_rst_done", 32'(done), 0);
    chk("done_rst_busy", 32'(busy), 0);
    keys   = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_done", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
